// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: passes processor dmem accesses through to the syncram and serves
// the 16-word I/O window (byte TX FIFO, status, cycle counter, scratch) with matching latency.
module dmem_mmio_responder #(
    parameter int DEPTH = 8,
    parameter logic [11:0] WIN_BASE = 12'hFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    fifo [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf, sel_mmio, in_window, win_wr, push, pop, full, accept;
    logic [31:0]   mmio_rdata, cycle, scratch, status, rdata;
    logic [3:0]    offset;

    assign offset      = address_dmem[3:0];
    assign in_window   = address_dmem[11:4] == WIN_BASE[11:4];
    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren && !in_window && reset;
    assign win_wr      = wren && in_window;
    assign push        = win_wr && offset == 4'hC;
    assign full        = count == CW'(DEPTH);
    assign tx_valid    = count != '0;
    assign pop         = tx_valid && tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign accept      = push && (!full || pop);
    assign tx_byte     = tx_valid ? fifo[rd_ptr] : 8'h00;
    assign status      = {25'b0, ovf, full, ~tx_valid, 4'(count)};
    assign rdata       = !in_window     ? 32'h0 :
                         offset == 4'hD ? status :
                         offset == 4'hE ? cycle :
                         offset == 4'hF ? scratch : 32'h0;
    assign q_dmem      = sel_mmio ? mmio_rdata : mem_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            cycle      <= 32'h0;
            scratch    <= 32'h0;
            sel_mmio   <= 1'b1;
            mmio_rdata <= 32'h0;
        end else begin
            sel_mmio   <= in_window;
            mmio_rdata <= rdata;
            cycle      <= (win_wr && offset == 4'hE) ? data : cycle + 32'd1;
            if (win_wr && offset == 4'hF) scratch <= data;
            if (push && !accept) ovf <= 1'b1;
            else if (win_wr && offset == 4'hD && data[6]) ovf <= 1'b0;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) fifo[wr_ptr] <= data[7:0];
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed vector table plus reset sequences against a behavioural dmem.
module tb_dmem_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address_dmem = 12'h0;
    logic [31:0] data = 32'h0;
    logic        wren = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] q_dmem, mem_data;
    logic [31:0] mem_q = 32'h0;
    logic [11:0] mem_address;
    logic        mem_wren, tx_valid;
    logic [7:0]  tx_byte;
    logic [31:0] ram [4096];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic        w, r, ew, cq;
        logic [31:0] eq;
        logic        ev;
        logic [7:0]  eb;
    } vec_t;
    vec_t v[$];

    dmem_mmio_responder dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r,
                       input logic ew, input logic cq, input logic [31:0] eq,
                       input logic ev, input logic [7:0] eb);
        v.push_back('{a, d, w, r, ew, cq, eq, ev, eb});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        //  addr    data          w  r  ew cq exp_q         ev eb
        add(12'hFFE, 32'h0,        0, 0, 0, 1, 32'h0,        0, 8'h00); // first cycle read is 0
        add(12'h010, 32'h1234,     1, 0, 1, 0, 32'h0,        0, 8'h00);
        add(12'h010, 32'h0,        0, 0, 0, 1, 32'h1234,     0, 8'h00);
        add(12'hFFC, 32'h41,       1, 0, 0, 1, 32'h0,        1, 8'h41);
        add(12'hFFC, 32'h42,       1, 0, 0, 1, 32'h0,        1, 8'h41);
        add(12'hFFC, 32'h43,       1, 0, 0, 1, 32'h0,        1, 8'h41);
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h03,       1, 8'h41);
        add(12'h020, 32'h0,        0, 1, 0, 1, 32'h0,        1, 8'h42);
        add(12'h020, 32'h0,        0, 1, 0, 1, 32'h0,        1, 8'h43);
        add(12'hFFD, 32'h0,        0, 1, 0, 1, 32'h01,       0, 8'h00);
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h10,       0, 8'h00);
        for (int i = 0; i < 9; i++)
            add(12'hFFC, 32'h60 + i,  1, 0, 0, 1, 32'h0,     1, 8'h60);
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h68,       1, 8'h60);
        add(12'hFFD, 32'h40,       1, 0, 0, 1, 32'h68,       1, 8'h60);
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h28,       1, 8'h60);
        add(12'hFFC, 32'h55,       1, 1, 0, 1, 32'h0,        1, 8'h61); // push+pop at full
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h28,       1, 8'h61);
        for (int i = 0; i < 6; i++)
            add(12'h020, 32'h0,    0, 1, 0, 1, 32'h0,        1, 8'h62 + 8'(i));
        add(12'h020, 32'h0,        0, 1, 0, 1, 32'h0,        1, 8'h55);
        add(12'h020, 32'h0,        0, 1, 0, 1, 32'h0,        0, 8'h00);
        add(12'hFFD, 32'h0,        0, 0, 0, 1, 32'h10,       0, 8'h00);
        add(12'hFFE, 32'hFFFFFFFE, 1, 0, 0, 0, 32'h0,        0, 8'h00);
        add(12'hFFE, 32'h0,        0, 0, 0, 1, 32'hFFFFFFFE, 0, 8'h00);
        add(12'hFFE, 32'h0,        0, 0, 0, 1, 32'hFFFFFFFF, 0, 8'h00);
        add(12'hFFE, 32'h0,        0, 0, 0, 1, 32'h0,        0, 8'h00);
        add(12'hFF3, 32'hDEADBEEF, 1, 0, 0, 1, 32'h0,        0, 8'h00);
        add(12'hFFF, 32'hCAFEF00D, 1, 0, 0, 1, 32'h0,        0, 8'h00);
        add(12'hFFF, 32'h0,        0, 0, 0, 1, 32'hCAFEF00D, 0, 8'h00);
        add(12'hFF3, 32'h0,        0, 0, 0, 1, 32'h0,        0, 8'h00);
        add(12'h010, 32'h0,        0, 0, 0, 1, 32'h1234,     0, 8'h00);

        address_dmem = 12'h010;
        wren = 1'b1;
        tick();
        tick();
        chk("rst_q", q_dmem, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_byte", {24'b0, tx_byte}, 32'h0);
        chk("rst_mem_wren", {31'b0, mem_wren}, 32'h0);
        reset = 1'b1;

        foreach (v[i]) begin
            address_dmem = v[i].a;
            data = v[i].d;
            wren = v[i].w;
            tx_ready = v[i].r;
            #1;
            chk($sformatf("v%0d_mem_wren", i), {31'b0, mem_wren}, {31'b0, v[i].ew});
            @(posedge clock);
            #1;
            if (v[i].cq) chk($sformatf("v%0d_q", i), q_dmem, v[i].eq);
            chk($sformatf("v%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, v[i].ev});
            chk($sformatf("v%0d_tx_byte", i), {24'b0, tx_byte}, {24'b0, v[i].eb});
        end
        chk("ram_ff3_untouched", ram[12'hFF3], 32'h0);
        chk("ram_fff_untouched", ram[12'hFFF], 32'h0);

        tx_ready = 1'b0;
        address_dmem = 12'hFFC;
        wren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 32'h70 + i;
            tick();
        end
        chk("mid_pre_valid", {31'b0, tx_valid}, 32'h1);
        chk("mid_pre_byte", {24'b0, tx_byte}, 32'h70);
        address_dmem = 12'h030;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("mid_rst_byte", {24'b0, tx_byte}, 32'h0);
        chk("mid_rst_q", q_dmem, 32'h0);
        chk("mid_rst_mem_wren", {31'b0, mem_wren}, 32'h0);
        tick();
        reset = 1'b1;
        wren = 1'b0;
        address_dmem = 12'hFFE;
        tick();
        chk("post_rst_cycle", q_dmem, 32'h0);
        address_dmem = 12'hFFD;
        tick();
        chk("post_rst_status", q_dmem, 32'h10);
        address_dmem = 12'hFFF;
        tick();
        chk("post_rst_scratch", q_dmem, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder on the processor's data-memory port. It sits between the processor's dmem outputs (address, write data, write enable) and the dmem syncram, and answers them. Addresses 0xFF0–0xFFF form an I/O window that it serves itself. Every other address passes through to dmem unchanged. The window contains an 8-entry byte TX FIFO with a valid/ready drain port, a status register, a free-running 32-bit cycle counter and a scratch register. Read latency matches dmem, so the processor cannot tell MMIO reads from memory reads.

## Interface
- DEPTH, 8: TX FIFO entries. Power of two, 2–16.
- WIN_BASE, 12'hFF0: base of the 16-word MMIO window. Low 4 bits must be 0.

Ports:
- clock, in, 1: single clock. Integration drives it with the dmem clock.
- reset, in, 1: asynchronous, active-low.
- address_dmem, in, 12: word address from the processor.
- data, in, 32: write data from the processor.
- wren, in, 1: write enable from the processor.
- q_dmem, out, 32: read data to the processor.
- mem_address, out, 12: to dmem. Always equals address_dmem.
- mem_data, out, 32: to dmem. Always equals data.
- mem_wren, out, 1: to dmem. Equals wren && !in_window && reset.
- mem_q, in, 32: dmem read data. Valid one clock after the address.
- tx_byte, out, 8: FIFO head (show-ahead).
- tx_valid, out, 1: FIFO non-empty.
- tx_ready, in, 1: consumer accepts tx_byte on an edge where tx_valid && tx_ready.

## Operation
- in_window = address_dmem[11:4] == WIN_BASE[11:4]. Decoding is combinational.
- Register map (word offsets within the window):
  - 0xC TXDATA: a write pushes data[7:0]. A read returns 0.
  - 0xD STATUS: a read returns {25'b0, ovf, full, empty, count[3:0]}. Writing data[6]=1 clears ovf. All other bits are read-only.
  - 0xE CYCLE: a read returns the counter. A write loads data.
  - 0xF SCRATCH: 32-bit read/write.
  - All other offsets read 0; writes to them are ignored.
- Read path:
  - On each edge, register sel_mmio <= in_window and mmio_rdata <= decoded value.
  - q_dmem = sel_mmio ? mmio_rdata : mem_q.
- FIFO:
  - push = wren && offset==0xC. pop = tx_valid && tx_ready.
  - A push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs on the same edge.
  - A rejected push drops the byte, sets ovf (sticky) and leaves the FIFO unchanged.
  - Simultaneous push and pop leaves count unchanged; the head advances and the new byte is written at the tail.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is 0..DEPTH.
- CYCLE increments by 1 every clock and wraps 0xFFFFFFFF -> 0. A write takes priority over the increment: the written value appears next cycle and increments from there.
- An ovf set (rejected push) and an ovf clear (STATUS write) cannot coincide, because only one address is presented per cycle.

## Timing
- Reset values (asynchronous, while reset=0):
  - count=0, pointers=0, ovf=0, CYCLE=0, SCRATCH=0.
  - sel_mmio=1 and mmio_rdata=0, so q_dmem=0.
  - tx_valid=0, tx_byte=0.
  - mem_wren is forced to 0.
- Deassertion is sampled at the next edge; CYCLE reads 0 on the first edge after release.
- Read latency: data for the address presented before edge N appears on q_dmem after edge N, for both MMIO and dmem.
- Register reads return pre-edge state. A STATUS read on the same edge as a push shows the old count. A CYCLE read shows the value before the increment.
- A pushed byte appears on tx_byte/tx_valid one edge after the push; there is no bypass path.
- tx_valid drops on the edge that pops the last entry (when there is no simultaneous push).
- Reset asserted mid-operation clears FIFO contents immediately; any pending bytes are lost.

## Test plan
- Reset and pass-through: hold reset=0 -> q_dmem=0, tx_valid=0, mem_wren=0. Release, write 0x1234 to address 0x010, then read it -> mem_wren pulses once and q_dmem=0x1234 one edge after the read address.
- FIFO order: push 0x41, 0x42, 0x43 with tx_ready=0 -> STATUS=0x03. Raise tx_ready -> bytes leave as 0x41, 0x42, 0x43 on consecutive edges, then STATUS=0x10 (empty).
- Overflow: push 9 bytes with tx_ready=0 -> STATUS=0x68 (ovf, full, count 8) and the 9th byte is dropped. Write STATUS with 0x40 -> reads 0x28.
- Full with simultaneous push and pop: at count 8, push 0x55 while tx_ready=1 -> count stays 8, ovf stays 0, and 0x55 emerges 8th.
- Cycle counter: write CYCLE=0xFFFFFFFE, then read on the next two cycles -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then wraps to 0.
- Window isolation: writes to offset 0x3 and to SCRATCH -> mem_wren stays 0, SCRATCH reads back its value, offset 0x3 reads 0, and dmem contents are unchanged.
